int_ctrl: RTL and testbench
===========================

INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 Parameter NUM_SRC, default 8, interrupt source count; legal range 1..16.
REQ-002 Parameter DATA_W, default 16, bus and vector width.
REQ-003 Parameter VEC_RST, default 16'h0010, reset value of the vector base register.
REQ-004 Clocking and reset: one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  system clock; all state updates on the rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 src_irq  in  NUM_SRC  level inputs; a rising edge requests service.
REQ-008 cpu_int  out  1  interrupt request to the control unit.
REQ-009 cpu_ack  in  1  one-cycle pulse; the control unit has accepted the request.
REQ-010 cpu_rit  in  1  one-cycle pulse; return-from-interrupt executed.
REQ-011 vec_out  out  DATA_W  handler address (vector base + winning index).
REQ-012 cfg_write  in  1  register write strobe.
REQ-013 cfg_addr  in  2  register select: 0 mask, 1 pending, 2 in-service, 3 vector base.
REQ-014 cfg_wdata  in  DATA_W  write data.
REQ-015 cfg_rdata  out  DATA_W  combinational read of the register at cfg_addr, zero-extended.

Function
REQ-016 The block SHALL register src_irq once and set pending[i] when the current sample is 1 and the previous sample is 0.
REQ-017 mask bit 1 SHALL enable a source; masked sources still latch pending.
REQ-018 Priority SHALL be fixed, with index 0 highest; the winner is the lowest i where pending & mask is set.
REQ-019 FSM states: IDLE, REQ, SERVICE.
REQ-020 IDLE -> REQ when a candidate exists; the winning index is captured into cur_idx; cpu_int is registered high in REQ.
REQ-021 REQ -> SERVICE on cpu_ack: clear pending[cur_idx], set inservice[cur_idx], drop cpu_int the next cycle.
REQ-022 vec_out SHALL equal vec_base + cur_idx (DATA_W-bit add, wrap-around ignored), and SHALL hold stable from entering REQ until leaving SERVICE.
REQ-023 SERVICE -> IDLE on cpu_rit: clear the highest-priority set inservice bit.
REQ-024 cpu_rit in IDLE or REQ SHALL be ignored; cpu_ack outside REQ SHALL be ignored.
REQ-025 If the winner is masked or cleared while in REQ before cpu_ack, the FSM SHALL return to IDLE and drop cpu_int the next cycle.
REQ-026 Writing a 1 to a pending bit at cfg_addr 1 SHALL clear that bit; if an edge arrives in the same cycle, set wins.
REQ-027 cfg_addr 2 SHALL be read-only; writes are ignored.
REQ-028 Simultaneous cpu_ack and a new edge on cur_idx SHALL leave pending[cur_idx] set, because the new edge is a fresh request.
REQ-029 Unused upper register bits SHALL read 0 and ignore writes.

Reset
REQ-030 On rst: mask 0, pending 0, inservice 0, edge samples 0, vec_base VEC_RST, state IDLE, cpu_int 0, cur_idx 0, vec_out VEC_RST.
REQ-031 rst asserted mid-service SHALL abandon the service immediately; no pending state is retained.
REQ-032 The first clock after rst deassertion SHALL NOT detect edges on sources already high at reset.

Configuration
REQ-033 Macro INTC_NESTING_EN. When defined, the SERVICE state SHALL re-enter REQ for a candidate strictly higher in priority than every set inservice bit. The return to SERVICE occurs on cpu_ack, and SERVICE exits to IDLE only when inservice becomes 0. The previous cur_idx SHALL be restored on cpu_rit to the highest-priority remaining inservice bit.
REQ-034 Without INTC_NESTING_EN, no request SHALL be raised while inservice is nonzero, and at most one inservice bit is ever set.

Structure
REQ-035 The shared CPU package SHALL hold: FSM state encodings, register address constants (INTC_MASK, INTC_PEND, INTC_ISR, INTC_VBASE), and the VEC_RST default.
REQ-036 One sub-module, int_prio_enc: a combinational NUM_SRC-input lowest-index priority encoder with index and valid outputs; it is used for both candidate and inservice selection.

Verification
REQ-037 Mask 8'h04, rising edge on src 2 -> cpu_int high 2 cycles later, vec_out 16'h0012; cpu_ack -> pending 0, inservice 8'h04; cpu_rit -> inservice 0, state IDLE.
REQ-038 Mask 8'hFF, edges on src 5 and src 1 in the same cycle -> vec_out 16'h0011 first; after cpu_rit -> second request with vec_out 16'h0015.
REQ-039 Mask 0, edge on src 3 -> pending 8'h08, cpu_int stays low; then write mask 8'h08 -> cpu_int asserts.
REQ-040 In REQ for src 4, clear mask bit 4 before cpu_ack -> cpu_int drops, state IDLE, pending bit 4 still set.
REQ-041 With INTC_NESTING_EN, in service of src 6, edge on src 0 -> cpu_int reasserts with vec_out 16'h0010; two cpu_rit pulses -> inservice 8'h40 then 0. Without the macro -> no reassertion until the first cpu_rit.
REQ-042 Assert rst while inservice 8'h02 and cpu_int high -> all outputs at reset values asynchronously; source held high through reset -> no pending set after release.

Source files
------------

// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller: FSM state encodings,
// register address map and the default vector base.
package int_ctrl_pkg;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StReq     = 2'd1;
  localparam logic [1:0] StService = 2'd2;

  typedef logic [1:0] intc_addr_t;

  localparam intc_addr_t INTC_MASK  = 2'd0;
  localparam intc_addr_t INTC_PEND  = 2'd1;
  localparam intc_addr_t INTC_ISR   = 2'd2;
  localparam intc_addr_t INTC_VBASE = 2'd3;

  localparam logic [15:0] INTC_VEC_RST = 16'h0010;

  // Index width for an n-source encoder; a single source still needs one bit.
  function automatic int unsigned intc_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-wins priority encoder; shared by candidate and in-service selection.
module int_prio_enc
  import int_ctrl_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = intc_idx_w(N)
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan from the top so the lowest set index is the last assignment.
  always_comb begin
    idx = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

  assign valid = |req;

endmodule

// File: rtl/int_ctrl.sv
// Fixed-priority interrupt controller with edge-latched sources and a vectored request.
// Define INTC_NESTING_EN to allow higher-priority sources to preempt a running handler.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int unsigned       NUM_SRC = 8,
  parameter int unsigned       DATA_W  = 16,
  parameter logic [DATA_W-1:0] VEC_RST = DATA_W'(INTC_VEC_RST)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_irq,
  output logic               cpu_int,
  input  logic               cpu_ack,
  input  logic               cpu_rit,
  output logic [DATA_W-1:0]  vec_out,
  input  logic               cfg_write,
  input  logic [1:0]         cfg_addr,
  input  logic [DATA_W-1:0]  cfg_wdata,
  output logic [DATA_W-1:0]  cfg_rdata
);

  localparam int unsigned IDX_W = intc_idx_w(NUM_SRC);

  logic [NUM_SRC-1:0] src_q;
  logic               first_q;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] isr_q, isr_d;
  logic [DATA_W-1:0]  vbase_q, vbase_d;
  logic [DATA_W-1:0]  vec_q, vec_d;
  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   cur_idx_q, cur_idx_d;
  logic               cpu_int_q;

  logic [NUM_SRC-1:0] src_rise, cand, cur_oh, isr_top_oh, pend_clr, wdata_src;
  logic [IDX_W-1:0]   cand_idx, isr_idx, load_idx;
  logic               cand_valid, isr_valid, win_live;
  logic               load, ack_set, rit_clr;
  logic               wr_mask, wr_pend, wr_vbase;
  logic [DATA_W-1:0]  load_ext;

  // Sources already high when reset releases must not look like fresh edges.
  assign src_rise  = src_irq & ~src_q & {NUM_SRC{~first_q}};
  assign cand      = pend_q & mask_q;
  assign cur_oh    = NUM_SRC'(1) << cur_idx_q;
  assign isr_top_oh = NUM_SRC'(1) << isr_idx;
  assign win_live  = pend_q[cur_idx_q] & mask_q[cur_idx_q];
  assign wdata_src = cfg_wdata[NUM_SRC-1:0];

  assign wr_mask  = cfg_write && (cfg_addr == INTC_MASK);
  assign wr_pend  = cfg_write && (cfg_addr == INTC_PEND);
  assign wr_vbase = cfg_write && (cfg_addr == INTC_VBASE);

  int_prio_enc #(
    .N     (NUM_SRC),
    .IDX_W (IDX_W)
  ) u_cand_enc (
    .req   (cand),
    .idx   (cand_idx),
    .valid (cand_valid)
  );

  int_prio_enc #(
    .N     (NUM_SRC),
    .IDX_W (IDX_W)
  ) u_isr_enc (
    .req   (isr_q),
    .idx   (isr_idx),
    .valid (isr_valid)
  );

`ifdef INTC_NESTING_EN
  logic [NUM_SRC-1:0] isr_rest;
  logic [IDX_W-1:0]   rest_idx;
  logic               rest_valid;

  // What remains in service once the innermost handler returns.
  assign isr_rest = isr_q & ~isr_top_oh;

  int_prio_enc #(
    .N     (NUM_SRC),
    .IDX_W (IDX_W)
  ) u_rest_enc (
    .req   (isr_rest),
    .idx   (rest_idx),
    .valid (rest_valid)
  );
`endif

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_idx = cand_idx;
    ack_set  = 1'b0;
    rit_clr  = 1'b0;

    case (state_q)
      StIdle: begin
        if (cand_valid && !isr_valid) begin
          state_d = StReq;
          load    = 1'b1;
        end
      end

      StReq: begin
        if (!win_live) begin
          // Winner withdrawn: fall back to the interrupted handler, if any.
          if (isr_valid) begin
            state_d  = StService;
            load     = 1'b1;
            load_idx = isr_idx;
          end else begin
            state_d = StIdle;
          end
        end else if (cpu_ack) begin
          state_d = StService;
          ack_set = 1'b1;
        end
      end

      StService: begin
        if (cpu_rit) begin
          rit_clr = 1'b1;
`ifdef INTC_NESTING_EN
          if (rest_valid) begin
            load     = 1'b1;
            load_idx = rest_idx;
          end else begin
            state_d = StIdle;
          end
`else
          state_d = StIdle;
`endif
        end
`ifdef INTC_NESTING_EN
        else if (cand_valid && (cand_idx < isr_idx)) begin
          state_d = StReq;
          load    = 1'b1;
        end
`endif
      end

      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cur_idx_d = cur_idx_q;
    vec_d     = vec_q;
    load_ext  = '0;
    load_ext[IDX_W-1:0] = load_idx;
    if (load) begin
      cur_idx_d = load_idx;
      vec_d     = vbase_q + load_ext;
    end
  end

  // A rising edge in the same cycle as a clear (write or acknowledge) wins.
  always_comb begin
    pend_clr = wr_pend ? wdata_src : '0;
    if (ack_set) pend_clr = pend_clr | cur_oh;
    pend_d = (pend_q & ~pend_clr) | src_rise;

    isr_d = isr_q;
    if (ack_set) isr_d = isr_d | cur_oh;
    if (rit_clr) isr_d = isr_d & ~isr_top_oh;

    mask_d  = wr_mask ? wdata_src : mask_q;
    vbase_d = wr_vbase ? cfg_wdata : vbase_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q     <= '0;
      first_q   <= 1'b1;
      mask_q    <= '0;
      pend_q    <= '0;
      isr_q     <= '0;
      vbase_q   <= VEC_RST;
      vec_q     <= VEC_RST;
      state_q   <= StIdle;
      cur_idx_q <= '0;
      cpu_int_q <= 1'b0;
    end else begin
      src_q     <= src_irq;
      first_q   <= 1'b0;
      mask_q    <= mask_d;
      pend_q    <= pend_d;
      isr_q     <= isr_d;
      vbase_q   <= vbase_d;
      vec_q     <= vec_d;
      state_q   <= state_d;
      cur_idx_q <= cur_idx_d;
      cpu_int_q <= (state_d == StReq);
    end
  end

  assign cpu_int = cpu_int_q;
  assign vec_out = vec_q;

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      INTC_MASK:  cfg_rdata[NUM_SRC-1:0] = mask_q;
      INTC_PEND:  cfg_rdata[NUM_SRC-1:0] = pend_q;
      INTC_ISR:   cfg_rdata[NUM_SRC-1:0] = isr_q;
      default:    cfg_rdata = vbase_q;
    endcase
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Scoreboard bench for int_ctrl: expected request vectors and register probes are queued
// by the stimulus and checked by separate monitor processes.
module tb_int_ctrl;

  localparam int unsigned NUM_SRC = 8;
  localparam int unsigned DATA_W  = 16;

  localparam logic [32:0] M_INT = 33'h1_0000_0000;
  localparam logic [32:0] M_VEC = 33'h0_FFFF_0000;
  localparam logic [32:0] M_RD  = 33'h0_0000_FFFF;

  logic               clk = 1'b0;
  logic               rst;
  logic [NUM_SRC-1:0] src_irq;
  logic               cpu_int;
  logic               cpu_ack;
  logic               cpu_rit;
  logic [DATA_W-1:0]  vec_out;
  logic               cfg_write;
  logic [1:0]         cfg_addr;
  logic [DATA_W-1:0]  cfg_wdata;
  logic [DATA_W-1:0]  cfg_rdata;

  always #10 clk = ~clk;

  int_ctrl #(
    .NUM_SRC (NUM_SRC),
    .DATA_W  (DATA_W),
    .VEC_RST (16'h0010)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .src_irq   (src_irq),
    .cpu_int   (cpu_int),
    .cpu_ack   (cpu_ack),
    .cpu_rit   (cpu_rit),
    .vec_out   (vec_out),
    .cfg_write (cfg_write),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  string       name_q[$];
  logic [32:0] mask_q[$];
  logic [32:0] val_q[$];
  logic [15:0] int_q[$];
  event        probe_ev;
  logic        int_prev = 1'b0;

  // Probe monitor: compares masked {cpu_int, vec_out, cfg_rdata} against queued expectations.
  initial forever begin
    @(probe_ev);
    while (name_q.size() > 0) begin
      string       nm;
      logic [32:0] m, v, got;
      nm  = name_q.pop_front();
      m   = mask_q.pop_front();
      v   = val_q.pop_front();
      got = {cpu_int, vec_out, cfg_rdata} & m;
      n_cmp++;
      if (got !== (v & m)) begin
        n_err++;
        $display("FAIL %s: got %h, want %h", nm, got, v & m);
      end
    end
  end

  // Request monitor: every rising cpu_int must match the next queued vector.
  initial forever begin
    @(negedge clk);
    if (cpu_int && !int_prev) begin
      n_cmp++;
      if (int_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_request: got vec %h, want no request", vec_out);
      end else begin
        logic [15:0] exp_vec;
        exp_vec = int_q.pop_front();
        if (vec_out !== exp_vec) begin
          n_err++;
          $display("FAIL request_vec: got %h, want %h", vec_out, exp_vec);
        end
      end
    end
    int_prev = cpu_int;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk(input string nm, input logic [32:0] m, input logic [32:0] v);
    #1;
    name_q.push_back(nm);
    mask_q.push_back(m);
    val_q.push_back(v);
    -> probe_ev;
    #1;
  endtask

  task automatic chk_int(input string nm, input logic b);
    chk(nm, M_INT, {b, 32'h0});
  endtask

  task automatic chk_vec(input string nm, input logic [15:0] v);
    chk(nm, M_VEC, {1'b0, v, 16'h0});
  endtask

  task automatic chk_rd(input string nm, input logic [1:0] a, input logic [15:0] v);
    cfg_addr = a;
    chk(nm, M_RD, {17'h0, v});
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    cfg_write = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    tick(1);
    cfg_write = 1'b0;
  endtask

  task automatic ack();
    cpu_ack = 1'b1;
    tick(1);
    cpu_ack = 1'b0;
  endtask

  task automatic rit();
    cpu_rit = 1'b1;
    tick(1);
    cpu_rit = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    src_irq   = '0;
    cpu_ack   = 1'b0;
    cpu_rit   = 1'b0;
    cfg_write = 1'b0;
    cfg_addr  = 2'd0;
    cfg_wdata = '0;
    tick(2);
    rst = 1'b0;
    tick(1);

    // Reset state
    chk_int("rst_int", 1'b0);
    chk_vec("rst_vec", 16'h0010);
    chk_rd("rst_mask", 2'd0, 16'h0000);
    chk_rd("rst_vbase", 2'd3, 16'h0010);

    // Single source, full handshake
    wr(2'd0, 16'h0004);
    int_q.push_back(16'h0012);
    src_irq = 8'h04;
    tick(1);
    chk_int("t1_int_early", 1'b0);
    chk_rd("t1_pend", 2'd1, 16'h0004);
    tick(1);
    chk_int("t1_int", 1'b1);
    chk_vec("t1_vec", 16'h0012);
    ack();
    chk_int("t1_int_drop", 1'b0);
    chk_rd("t1_pend_clr", 2'd1, 16'h0000);
    chk_rd("t1_isr", 2'd2, 16'h0004);
    rit();
    chk_rd("t1_isr_clr", 2'd2, 16'h0000);
    src_irq = 8'h00;
    tick(2);
    chk_int("t1_idle", 1'b0);

    // Two simultaneous edges: index 1 first, then index 5
    wr(2'd0, 16'h00FF);
    int_q.push_back(16'h0011);
    int_q.push_back(16'h0015);
    src_irq = 8'h22;
    tick(2);
    chk_vec("t2_vec_first", 16'h0011);
    ack();
    chk_rd("t2_isr", 2'd2, 16'h0002);
    chk_rd("t2_pend", 2'd1, 16'h0020);
    rit();
    chk_int("t2_gap", 1'b0);
    tick(1);
    chk_int("t2_int_second", 1'b1);
    chk_vec("t2_vec_second", 16'h0015);
    ack();
    rit();
    src_irq = 8'h00;

    // Masked source latches pending without a request
    wr(2'd0, 16'h0000);
    src_irq = 8'h08;
    tick(2);
    chk_rd("t3_pend", 2'd1, 16'h0008);
    chk_int("t3_masked", 1'b0);
    int_q.push_back(16'h0013);
    wr(2'd0, 16'h0008);
    tick(1);
    chk_int("t3_unmasked", 1'b1);
    chk_vec("t3_vec", 16'h0013);
    ack();
    rit();
    src_irq = 8'h00;

    // Winner masked while waiting for acknowledge
    wr(2'd0, 16'h0010);
    int_q.push_back(16'h0014);
    src_irq = 8'h10;
    tick(2);
    chk_int("t4_int", 1'b1);
    wr(2'd0, 16'h0000);
    tick(1);
    chk_int("t4_withdrawn", 1'b0);
    chk_rd("t4_pend_kept", 2'd1, 16'h0010);
    tick(3);
    chk_int("t4_stays_low", 1'b0);
    wr(2'd1, 16'h0010);
    chk_rd("t4_pend_w1c", 2'd1, 16'h0000);
    // Edge and clear in the same cycle: the edge wins
    src_irq   = 8'h90;
    cfg_write = 1'b1;
    cfg_addr  = 2'd1;
    cfg_wdata = 16'h0080;
    tick(1);
    cfg_write = 1'b0;
    chk_rd("t4_set_wins", 2'd1, 16'h0080);
    wr(2'd1, 16'h0080);
    chk_rd("t4_pend_zero", 2'd1, 16'h0000);
    wr(2'd0, 16'hFFFF);
    chk_rd("t4_mask_upper", 2'd0, 16'h00FF);
    wr(2'd0, 16'h0000);
    src_irq = 8'h00;

    // Higher-priority edge during service
    wr(2'd0, 16'h00FF);
    int_q.push_back(16'h0016);
    src_irq = 8'h40;
    tick(2);
    ack();
    wr(2'd2, 16'h0000);
    chk_rd("t5_isr_ro", 2'd2, 16'h0040);
    src_irq = 8'h41;
`ifdef INTC_NESTING_EN
    int_q.push_back(16'h0010);
    tick(2);
    chk_int("t5_nest_int", 1'b1);
    chk_vec("t5_nest_vec", 16'h0010);
    ack();
    chk_rd("t5_nest_isr", 2'd2, 16'h0041);
    rit();
    chk_rd("t5_isr_after_rit1", 2'd2, 16'h0040);
    chk_vec("t5_vec_restored", 16'h0016);
    chk_int("t5_int_low", 1'b0);
    rit();
    chk_rd("t5_isr_after_rit2", 2'd2, 16'h0000);
`else
    tick(2);
    chk_rd("t5_pend0", 2'd1, 16'h0001);
    chk_int("t5_no_nest", 1'b0);
    tick(2);
    chk_int("t5_no_nest_later", 1'b0);
    int_q.push_back(16'h0010);
    rit();
    chk_rd("t5_isr_after_rit", 2'd2, 16'h0000);
    tick(1);
    chk_int("t5_int_after_rit", 1'b1);
    chk_vec("t5_vec_after_rit", 16'h0010);
    ack();
    rit();
    chk_rd("t5_isr_done", 2'd2, 16'h0000);
`endif
    src_irq = 8'h00;
    tick(1);

    // Asynchronous reset in the middle of a service
    int_q.push_back(16'h0011);
    src_irq = 8'h02;
    tick(2);
    ack();
    chk_rd("t6_isr", 2'd2, 16'h0002);
`ifdef INTC_NESTING_EN
    int_q.push_back(16'h0010);
    src_irq = 8'h03;
    tick(2);
    chk_int("t6_int_before_rst", 1'b1);
`endif
    rst = 1'b1;
    chk_int("t6_rst_int", 1'b0);
    chk_vec("t6_rst_vec", 16'h0010);
    chk_rd("t6_rst_isr", 2'd2, 16'h0000);
    chk_rd("t6_rst_pend", 2'd1, 16'h0000);
    chk_rd("t6_rst_mask", 2'd0, 16'h0000);
    tick(2);
    rst = 1'b0;
    tick(3);
    chk_rd("t6_no_edge_after_rst", 2'd1, 16'h0000);
    wr(2'd0, 16'h00FF);
    tick(2);
    chk_int("t6_no_request", 1'b0);
    src_irq = 8'h00;
    tick(2);

    n_cmp++;
    if (int_q.size() != 0) begin
      n_err++;
      $display("FAIL missing_requests: got %0d outstanding, want 0", int_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
